// File: rtl/mult_share_pkg.sv
// Shared types and constants for the multiplier-sharing controller.
package mult_share_pkg;

  localparam int OP_W       = 4;
  localparam int PROD_W     = 8;
  localparam int ID_W       = 1;
  localparam int SETTLE_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. Purely combinational; a lone request always
// wins, a tie goes to the input that did not win last time.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt
);

  // One-hot grant selection, suppressed entirely when not enabled.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one combinational 4x4 multiplier between two requesters: arbitrates,
// holds operands on the multiplier bus, waits SETTLE_CYC cycles, captures the
// product and returns it with the owner ID over a back-pressurable channel.
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_a,
  input  logic [OP_W-1:0]   req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_a,
  input  logic [OP_W-1:0]   req1_b,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_p,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [PROD_W-1:0] rsp_product,
  output logic [ID_W-1:0]   rsp_id,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt
);

  // Out-of-range settle values are clamped so the 4-bit counter never wraps.
  localparam int SETTLE_EFF = (SETTLE_CYC < 1) ? 1 :
                              ((SETTLE_CYC > SETTLE_MAX) ? SETTLE_MAX : SETTLE_CYC);
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_EFF - 1);

  state_t            state;
  state_t            state_nxt;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic [PROD_W-1:0] result;
  logic              last_grant;
  logic [3:0]        settle_cnt;
  logic [1:0]        gnt;
  logic              accept;
  logic [ID_W-1:0]   acc_id;
  logic              settle_done;
  logic              rsp_fire;

  rr_arb2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .en         (state == IDLE),
    .gnt        (gnt)
  );

  // The arbiter only grants a requester that is valid, so any grant is a handshake.
  assign req0_ready  = gnt[0];
  assign req1_ready  = gnt[1];
  assign accept      = |gnt;
  assign acc_id      = gnt[1];
  assign settle_done = (settle_cnt == 4'd0);
  assign rsp_fire    = (state == RESP) && rsp_ready;

  assign mul_a       = op_a;
  assign mul_b       = op_b;
  assign rsp_valid   = (state == RESP);
  assign rsp_product = result;
  assign busy        = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept -> settle -> hold response until consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = CALC;
      CALC:    if (settle_done) state_nxt = RESP;
      RESP:    if (rsp_ready)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner's operands and identity; they stay on the bus until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      rsp_id     <= '0;
      last_grant <= 1'b1;
    end else if (accept) begin
      op_a       <= gnt[1] ? req1_a : req0_a;
      op_b       <= gnt[1] ? req1_b : req0_b;
      rsp_id     <= acc_id;
      last_grant <= acc_id;
    end
  end

  // Count down the settle window while the multiplier output propagates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= 4'd0;
    end else if (accept) begin
      settle_cnt <= SETTLE_INIT;
    end else if ((state == CALC) && !settle_done) begin
      settle_cnt <= settle_cnt - 4'd1;
    end
  end

  // Capture the settled product on the last CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else if ((state == CALC) && settle_done) begin
      result <= mul_p;
    end
  end

  // Count consumed responses, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (rsp_fire) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
module tb_mult_share_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld [2][2];
  logic [3:0] opa [2][2];
  logic [3:0] opb [2][2];
  logic       rr  [2];
  logic       rdy0 [2];
  logic       rdy1 [2];
  logic [3:0] ma [2];
  logic [3:0] mb [2];
  logic [7:0] mp [2];
  logic       rv [2];
  logic [7:0] rp [2];
  logic       rid [2];
  logic       bsy [2];
  logic [7:0] dc [2];
  logic [7:0] d1, d2, d3;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    bit       inflight;
    int       acc;
    bit [3:0] oa;
    bit [3:0] ob;
    bit       id;
    bit       last;
    bit [7:0] done;
  } mdl_t;

  mdl_t m [2];
  int   settle [2] = '{1, 4};

  always #5 clk = ~clk;

  // Instance 0: combinational multiplier, one settle cycle.
  assign mp[0] = 8'(ma[0]) * 8'(mb[0]);

  // Instance 1: multiplier whose output lags its operands by three cycles.
  always @(posedge clk) begin
    d1 <= 8'(ma[1]) * 8'(mb[1]);
    d2 <= d1;
    d3 <= d2;
  end
  assign mp[1] = d3;

  mult_share_ctrl #(.SETTLE_CYC(1), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(vld[0][0]), .req0_ready(rdy0[0]), .req0_a(opa[0][0]), .req0_b(opb[0][0]),
    .req1_valid(vld[0][1]), .req1_ready(rdy1[0]), .req1_a(opa[0][1]), .req1_b(opb[0][1]),
    .mul_a(ma[0]), .mul_b(mb[0]), .mul_p(mp[0]),
    .rsp_valid(rv[0]), .rsp_ready(rr[0]), .rsp_product(rp[0]), .rsp_id(rid[0]),
    .busy(bsy[0]), .done_cnt(dc[0])
  );

  mult_share_ctrl #(.SETTLE_CYC(4), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(vld[1][0]), .req0_ready(rdy0[1]), .req0_a(opa[1][0]), .req0_b(opb[1][0]),
    .req1_valid(vld[1][1]), .req1_ready(rdy1[1]), .req1_a(opa[1][1]), .req1_b(opb[1][1]),
    .mul_a(ma[1]), .mul_b(mb[1]), .mul_p(mp[1]),
    .rsp_valid(rv[1]), .rsp_ready(rr[1]), .rsp_product(rp[1]), .rsp_id(rid[1]),
    .busy(bsy[1]), .done_cnt(dc[1])
  );

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: an operation is either absent or in flight since
  // some accept cycle; its response is visible SETTLE+1 cycles after accept.
  task automatic step(int i);
    bit    erv;
    int    g;
    string p;
    p = $sformatf("u%0d ", i);
    if (!rst_n) begin
      m[i].inflight = 0;
      m[i].last = 1;
      m[i].done = 0;
      m[i].oa = 0;
      m[i].ob = 0;
      m[i].id = 0;
      chk({p, "rst rsp_valid"}, int'(rv[i]), 0);
      chk({p, "rst busy"}, int'(bsy[i]), 0);
      chk({p, "rst req0_ready"}, int'(rdy0[i]), 0);
      chk({p, "rst req1_ready"}, int'(rdy1[i]), 0);
      chk({p, "rst done_cnt"}, int'(dc[i]), 0);
      chk({p, "rst mul_a"}, int'(ma[i]), 0);
      chk({p, "rst mul_b"}, int'(mb[i]), 0);
      chk({p, "rst rsp_product"}, int'(rp[i]), 0);
      chk({p, "rst rsp_id"}, int'(rid[i]), 0);
      return;
    end
    erv = m[i].inflight && ((cyc - m[i].acc) >= settle[i] + 1);
    g = -1;
    if (!m[i].inflight) begin
      if (vld[i][0] && vld[i][1]) g = m[i].last ? 0 : 1;
      else if (vld[i][0])         g = 0;
      else if (vld[i][1])         g = 1;
    end
    chk({p, "req0_ready"}, int'(rdy0[i]), int'(g == 0));
    chk({p, "req1_ready"}, int'(rdy1[i]), int'(g == 1));
    chk({p, "busy"}, int'(bsy[i]), int'(m[i].inflight));
    chk({p, "rsp_valid"}, int'(rv[i]), int'(erv));
    chk({p, "done_cnt"}, int'(dc[i]), int'(m[i].done));
    chk({p, "mul_a"}, int'(ma[i]), int'(m[i].oa));
    chk({p, "mul_b"}, int'(mb[i]), int'(m[i].ob));
    if (erv) begin
      chk({p, "rsp_product"}, int'(rp[i]), int'(m[i].oa) * int'(m[i].ob));
      chk({p, "rsp_id"}, int'(rid[i]), int'(m[i].id));
    end
    if (g >= 0) begin
      m[i].inflight = 1;
      m[i].acc = cyc;
      m[i].oa = opa[i][g];
      m[i].ob = opb[i][g];
      m[i].id = (g == 1);
      m[i].last = (g == 1);
    end else if (erv && rr[i]) begin
      m[i].inflight = 0;
      m[i].done = m[i].done + 8'd1;
    end
  endtask

  // Compare process: every cycle, both instances, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) step(i);
  end

  task automatic send(int i, int who, logic [3:0] a, logic [3:0] b);
    bit got;
    got = 0;
    @(posedge clk); #1;
    vld[i][who] = 1'b1;
    opa[i][who] = a;
    opb[i][who] = b;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = (who == 0) ? rdy0[i] : rdy1[i];
    end
    chk($sformatf("u%0d accept req%0d", i, who), int'(got), 1);
    @(posedge clk); #1;
    vld[i][who] = 1'b0;
    opa[i][who] = 4'($urandom);
    opb[i][who] = 4'($urandom);
  endtask

  task automatic wait_rv(int i, output int lat);
    bit seen;
    seen = 0;
    lat = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      lat++;
      seen = rv[i];
    end
    chk($sformatf("u%0d rsp_valid arrives", i), int'(seen), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_req(int who);
    bit hs;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      hs = vld[0][who] && ((who == 0) ? rdy0[0] : rdy1[0]);
      @(posedge clk); #1;
      if (hs) vld[0][who] = 1'b0;
      if (!vld[0][who] && ($urandom_range(0, 2) == 0)) begin
        vld[0][who] = 1'b1;
        opa[0][who] = 4'($urandom);
        opb[0][who] = 4'($urandom);
      end
    end
    @(posedge clk); #1;
    vld[0][who] = 1'b0;
  endtask

  task automatic rand_rsp();
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      rr[0] = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    rr[0] = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int eid [4] = '{0, 1, 0, 1};
    int ep  [4] = '{14, 16, 14, 16};
    for (int i = 0; i < 2; i++) begin
      rr[i] = 1'b1;
      for (int j = 0; j < 2; j++) begin
        vld[i][j] = 1'b0;
        opa[i][j] = 4'd0;
        opb[i][j] = 4'd0;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request, one settle cycle.
    send(0, 0, 4'd3, 4'd5);
    wait_rv(0, lat);
    chk("t1 latency", lat, 2);
    chk("t1 product", int'(rp[0]), 15);
    chk("t1 id", int'(rid[0]), 0);
    @(negedge clk);
    chk("t1 done_cnt", int'(dc[0]), 1);

    // Operand extremes.
    send(0, 1, 4'd15, 4'd15);
    wait_rv(0, lat);
    chk("t2 product 15x15", int'(rp[0]), 225);
    chk("t2 id", int'(rid[0]), 1);
    send(0, 0, 4'd0, 4'd9);
    wait_rv(0, lat);
    chk("t2 product 0x9", int'(rp[0]), 0);

    // Continuous contention from a fresh reset alternates 0,1,0,1.
    do_reset();
    vld[0][0] = 1'b1; opa[0][0] = 4'd2; opb[0][0] = 4'd7;
    vld[0][1] = 1'b1; opa[0][1] = 4'd4; opb[0][1] = 4'd4;
    for (int k = 0; k < 4; k++) begin
      wait_rv(0, lat);
      chk($sformatf("t3 id #%0d", k), int'(rid[0]), eid[k]);
      chk($sformatf("t3 product #%0d", k), int'(rp[0]), ep[k]);
    end
    @(posedge clk); #1;
    vld[0][0] = 1'b0;
    vld[0][1] = 1'b0;

    // Backpressure holds the response steady.
    rr[0] = 1'b0;
    send(0, 0, 4'd6, 4'd7);
    wait_rv(0, lat);
    repeat (10) begin
      @(negedge clk);
      chk("t4 held valid", int'(rv[0]), 1);
      chk("t4 held product", int'(rp[0]), 42);
      chk("t4 held id", int'(rid[0]), 0);
    end
    @(posedge clk); #1;
    rr[0] = 1'b1;
    @(negedge clk);
    chk("t4 done before accept", int'(dc[0]), 4);
    @(negedge clk);
    chk("t4 done after accept", int'(dc[0]), 5);
    chk("t4 valid dropped", int'(rv[0]), 0);

    // Four settle cycles against a three-cycle multiplier.
    send(1, 0, 4'd9, 4'd11);
    wait_rv(1, lat);
    chk("t5 latency", lat, 5);
    chk("t5 product", int'(rp[1]), 99);
    chk("t5 id", int'(rid[1]), 0);

    // Reset while an operation is settling.
    send(1, 0, 4'd12, 4'd12);
    @(posedge clk); #1;
    chk("t6 busy before reset", int'(bsy[1]), 1);
    rst_n = 1'b0;
    #1;
    chk("t6 rsp_valid in reset", int'(rv[1]), 0);
    chk("t6 busy in reset", int'(bsy[1]), 0);
    chk("t6 done_cnt in reset u1", int'(dc[1]), 0);
    chk("t6 done_cnt in reset u0", int'(dc[0]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(0, 0, 4'd1, 4'd1);
    wait_rv(0, lat);
    chk("t6 fresh product", int'(rp[0]), 1);
    chk("t6 fresh id", int'(rid[0]), 0);

    // Randomized traffic with random backpressure.
    fork
      rand_req(0);
      rand_req(1);
      rand_rsp();
    join
    repeat (30) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Sequencing and arbitration controller that shares one combinational 4x4 unsigned array multiplier between two requesters.
- Accepts operand pairs over valid/ready handshakes, grants round-robin, drives the multiplier operand bus, and waits a programmable settle time.
- Captures the 8-bit product and returns it with the winning requester's ID over a back-pressurable response channel.
- Sits between the tile's I/O decode logic and the multiplier datapath instance.

Parameters:
- SETTLE_CYC, 1, cycles mul_p is given to settle before capture; legal range 1..15.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  controller accepts requester 0 this cycle
- req0_a  in  4  requester 0 multiplicand
- req0_b  in  4  requester 0 multiplier
- req1_valid  in  1  requester 1 has an operand pair
- req1_ready  out  1  controller accepts requester 1 this cycle
- req1_a  in  4  requester 1 multiplicand
- req1_b  in  4  requester 1 multiplier
- mul_a  out  4  operand A to the shared multiplier
- mul_b  out  4  operand B to the shared multiplier
- mul_p  in  8  product from the shared multiplier
- rsp_valid  out  1  response holds a valid product
- rsp_ready  in  1  consumer accepts the response
- rsp_product  out  8  captured product
- rsp_id  out  1  requester that owns the response
- busy  out  1  high whenever state is not IDLE
- done_cnt  out  CNT_W  completed responses; wraps modulo 2^CNT_W

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, op_a=op_b=0, result=0, rsp_id=0, last_grant=1, settle_cnt=0, done_cnt=0.
  - All outputs are 0.
- mul_a/mul_b are driven from the op_a/op_b registers at all times, so they are 0 in reset and stable while the multiplier settles.
- IDLE:
  - Grant is combinational. If exactly one valid is high, grant it. If both are high, grant the requester != last_grant.
  - reqN_ready = (state==IDLE) & grant==N. At most one ready is high in any cycle.
  - On handshake (valid & ready): latch operands into op_a/op_b, record id, set last_grant=id, settle_cnt=SETTLE_CYC-1, go to CALC.
  - With no valid: stay in IDLE, no ready.
- CALC:
  - If settle_cnt==0: result<=mul_p, go to RESP. Otherwise decrement settle_cnt.
  - Both readys stay low.
- RESP:
  - rsp_valid=1; rsp_product/rsp_id are held stable until accepted.
  - On rsp_ready: done_cnt+1 (wrap), go to IDLE.
  - A new request cannot be accepted in the same cycle; it is accepted in IDLE the following cycle.
  - If rsp_ready stays low, hold indefinitely.
- Latency:
  - Handshake at cycle N → rsp_valid at cycle N+SETTLE_CYC+1.
  - Minimum spacing between accepts is SETTLE_CYC+2 cycles.
- Requesters must hold valid and operands stable until ready. Operand changes after the handshake do not affect the in-flight product.
- Arithmetic: unsigned 4x4 → 8-bit with no overflow; max 15*15=225.
- Fairness: under continuous contention, grants alternate 0,1,0,1, starting with 0 after reset.
- Reset mid-operation: the in-flight result is discarded and rsp_valid drops immediately (async). done_cnt clears.
- busy = (state != IDLE).

Decomposition:
- Package mult_share_pkg:
  - state enum {IDLE, CALC, RESP} (2-bit)
  - OP_W=4, PROD_W=8, ID_W=1 constants
  - max settle constant 15
- Sub-module rr_arb2: two-input round-robin arbiter.
  - Inputs: req[1:0], last_grant, en.
  - Output: one-hot gnt[1:0].
  - Purely combinational; reused for any future 2-port shared resource.

Test Plan:
- Single request, SETTLE_CYC=1: req0 a=3 b=5, rsp_ready=1 → req0_ready one cycle, rsp_valid 2 cycles after handshake, product=15, id=0, done_cnt=1.
- Max operands: req1 a=15 b=15 → product=225 (0xE1), id=1. Also 0*9 → product=0.
- Contention: both valid continuously, req0 (2,7) and req1 (4,4) re-presented after each accept → responses alternate id 0/14, 1/16, 0/14, 1/16. Readys are never both high.
- Backpressure: rsp_ready=0 for 10 cycles during a response for 6*7 → rsp_valid, product=42, and id stay stable. Neither req ready is asserted. Completion occurs on the cycle rsp_ready rises.
- SETTLE_CYC=4 with a mul_p model delayed 3 cycles: 9*11 → captured product=99; rsp_valid exactly 5 cycles after handshake.
- Reset in CALC after accepting 12*12 → rsp_valid=0, busy=0, done_cnt=0 immediately. After release, a fresh request 1*1 returns 1 with id 0.
